// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-side signal bundle for the two-port FIFO write arbiter.
// master drives requests and FIFO flags; slave is the arbiter itself.
interface fifo_write_arbiter_if #(
  parameter int STALL_WIDTH = 8
);
  logic                   enable;
  logic                   req0;
  logic                   req1;
  logic [7:0]             data0;
  logic [7:0]             data1;
  logic [3:0]             fifo_status;
  logic                   ack0;
  logic                   ack1;
  logic                   fifo_write;
  logic [7:0]             fifo_data;
  logic                   busy;
  logic [STALL_WIDTH-1:0] stall_count;

  modport master (
    output enable, req0, req1, data0, data1, fifo_status,
    input  ack0, ack1, fifo_write, fifo_data, busy, stall_count
  );

  modport slave (
    input  enable, req0, req1, data0, data1, fifo_status,
    output ack0, ack1, fifo_write, fifo_data, busy, stall_count
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Two-requester FIFO write arbiter: IDLE -> WRITE -> SETTLE, round-robin or fixed
// priority, with a saturating count of cycles blocked by FIFO Full.
module fifo_write_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int STALL_WIDTH    = 8
) (
  input logic                clk,
  input logic                reset,
  fifo_write_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, SETTLE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             req;
  logic [1:0][7:0]        data;
  logic                   grant, win, stall_inc;
  logic                   last_q;
  logic                   fifo_write_q, busy_q;
  logic [1:0]             ack_q;
  logic [7:0]             fifo_data_q;
  logic [STALL_WIDTH-1:0] stall_q;

  assign req  = {bus.req1, bus.req0};
  assign data = {bus.data1, bus.data0};

  // Requests and flags only matter in IDLE; WRITE/SETTLE run to completion.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    win       = 1'b0;
    stall_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && (|req)) begin
          if (bus.fifo_status[1]) begin
            stall_inc = (stall_q != '1);
          end else begin
            grant   = 1'b1;
            state_d = WRITE;
            if (req == 2'b11) win = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_q;
            else              win = req[1];
          end
        end
      end
      WRITE:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are set on the grant edge so they are high exactly for the WRITE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fifo_write_q <= 1'b0;
      ack_q        <= 2'b00;
      fifo_data_q  <= 8'h00;
      busy_q       <= 1'b0;
      stall_q      <= '0;
      last_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      fifo_write_q <= grant;
      ack_q        <= grant ? (2'b01 << win) : 2'b00;
      busy_q       <= (state_d != IDLE);
      if (grant) begin
        fifo_data_q <= data[win];
        last_q      <= win;
      end
      if (stall_inc) stall_q <= stall_q + STALL_WIDTH'(1);
    end
  end

  assign bus.fifo_write  = fifo_write_q;
  assign bus.ack0        = ack_q[0];
  assign bus.ack1        = ack_q[1];
  assign bus.fifo_data   = fifo_data_q;
  assign bus.busy        = busy_q;
  assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench: round-robin, fixed-priority and 4-bit-stall instances share one stimulus.
module tb_fifo_write_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.STALL_WIDTH(8)) bm ();
  fifo_write_arbiter_if #(.STALL_WIDTH(8)) bf ();
  fifo_write_arbiter_if #(.STALL_WIDTH(4)) bs ();

  fifo_write_arbiter #(.FIXED_PRIORITY(0), .STALL_WIDTH(8)) dut_rr  (.clk(clk), .reset(reset), .bus(bm));
  fifo_write_arbiter #(.FIXED_PRIORITY(1), .STALL_WIDTH(8)) dut_fp  (.clk(clk), .reset(reset), .bus(bf));
  fifo_write_arbiter #(.FIXED_PRIORITY(0), .STALL_WIDTH(4)) dut_sat (.clk(clk), .reset(reset), .bus(bs));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic r0, input logic r1,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [3:0] st);
    bm.enable = en; bm.req0 = r0; bm.req1 = r1; bm.data0 = d0; bm.data1 = d1; bm.fifo_status = st;
    bf.enable = en; bf.req0 = r0; bf.req1 = r1; bf.data0 = d0; bf.data1 = d1; bf.fifo_status = st;
    bs.enable = en; bs.req0 = r0; bs.req1 = r1; bs.data0 = d0; bs.data1 = d1; bs.fifo_status = st;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs of the round-robin instance.
  task automatic chk_m(input string t, input logic fw, input logic [7:0] d,
                       input logic a0, input logic a1, input logic b);
    chk({t, ".fifo_write"}, bm.fifo_write, fw);
    chk({t, ".fifo_data"},  bm.fifo_data,  d);
    chk({t, ".ack0"},       bm.ack0,       a0);
    chk({t, ".ack1"},       bm.ack1,       a1);
    chk({t, ".busy"},       bm.busy,       b);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
    tick();
    tick();
    chk_m("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset.stall", bm.stall_count, 0);
    reset = 1'b0;

    // Contention from reset: requester 0 wins the first tie, then alternation.
    drive(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_m($sformatf("rr%0d", k), 1'b1, (k % 2) ? 8'h22 : 8'h11, (k % 2) == 0, (k % 2) == 1, 1'b1);
      chk($sformatf("fp%0d.data", k), bf.fifo_data, 8'h11);
      chk($sformatf("fp%0d.ack1", k), bf.ack1, 1'b0);
      if (k == 3) drive(1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 4'h0);
      tick();
      chk($sformatf("rr%0d.settle_fw", k), bm.fifo_write, 1'b0);
      tick();
      chk($sformatf("rr%0d.idle_busy", k), bm.busy, 1'b0);
    end

    // Single requester 0.
    drive(1'b1, 1'b1, 1'b0, 8'h5A, 8'h00, 4'h0);
    tick();
    chk_m("single.write", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 4'h0);
    tick();
    chk_m("single.settle", 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    tick();
    chk_m("single.idle", 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);

    // Same requester again (lone request ignores history); non-Full flags are ignored.
    drive(1'b1, 1'b1, 1'b0, 8'h3C, 8'h00, 4'b1101);
    tick();
    chk_m("again.write", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 4'h0);
    tick();
    tick();

    // Enable low: no grant, no stall counting even with Full; dropped Req leaves no trace.
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h44, 4'b0010);
    tick();
    tick();
    chk_m("disabled", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("disabled.stall", bm.stall_count, 0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h44, 4'h0);
    tick();
    chk_m("dropped", 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);

    // Enable dropped mid-write does not abort.
    drive(1'b1, 1'b1, 1'b0, 8'h77, 8'h00, 4'h0);
    tick();
    chk_m("en_mid.write", 1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h77, 8'h00, 4'h0);
    tick();
    chk_m("en_mid.settle", 1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
    tick();

    // Full stall for 10 cycles with requester 1.
    drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h99, 4'b0010);
    repeat (10) tick();
    chk_m("stall", 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("stall.count", bm.stall_count, 10);
    chk("stall.count_sat", bs.stall_count, 10);
    drive(1'b1, 1'b0, 1'b1, 8'h00, 8'h99, 4'h0);
    tick();
    chk_m("stall.release", 1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
    chk("stall.count_hold", bm.stall_count, 10);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h99, 4'h0);
    tick();
    tick();

    // Saturation: 4-bit counter pins at 15, 8-bit keeps counting.
    drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 4'b0010);
    repeat (20) tick();
    chk("sat.count4", bs.stall_count, 15);
    chk("sat.count8", bm.stall_count, 30);
    repeat (3) tick();
    chk("sat.hold4", bs.stall_count, 15);
    chk("sat.count8b", bm.stall_count, 33);
    chk("sat.fw", bm.fifo_write, 1'b0);

    // Reset during WRITE abandons the transaction.
    drive(1'b1, 1'b1, 1'b0, 8'hA5, 8'h00, 4'h0);
    tick();
    chk_m("rst_mid.write", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'hA5, 8'h00, 4'h0);
    tick();
    chk_m("rst_mid.after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.stall", bm.stall_count, 0);
    chk("rst_mid.stall_sat", bs.stall_count, 0);
    reset = 1'b0;

    // Pointer is back at requester 1, so requester 0 wins the tie.
    drive(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 4'h0);
    tick();
    chk_m("post_rst.tie", 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
